// File: rtl/sobel_frame_ctrl.sv
// Frame sequencer for a Sobel edge pipeline: walks the pixel raster, drains
// the Sobel datapath, then holds the result on the display for a few vsyncs.
module sobel_frame_ctrl #(
    parameter int IMG_W       = 128,
    parameter int IMG_H       = 128,
    parameter int TIMEOUT     = 4096,
    parameter int SHOW_FRAMES = 1,
    localparam int XW         = $clog2(IMG_W),
    localparam int YW         = $clog2(IMG_H)
) (
    input  logic          sys_clk_i,
    input  logic          sys_rst_i,
    input  logic          start_i,
    input  logic          mode_i,
    input  logic          continuous_i,
    input  logic          src_valid_i,
    output logic          src_en_o,
    output logic [XW-1:0] pix_x_o,
    output logic [YW-1:0] pix_y_o,
    output logic          sof_o,
    output logic          eol_o,
    output logic          sobel_en_o,
    input  logic          sobel_done_i,
    input  logic          vsync_i,
    output logic          disp_sel_o,
    output logic          busy_o,
    output logic          frame_done_o,
    output logic          err_timeout_o,
    output logic [7:0]    frame_cnt_o
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int VW = $clog2(SHOW_FRAMES + 1);
    localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [VW-1:0] V_LAST = VW'(SHOW_FRAMES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FLUSH,
        SHOW,
        ERR
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [XW-1:0] x_cnt;
    logic [YW-1:0] y_cnt;
    logic [TW-1:0] t_cnt;
    logic [VW-1:0] v_cnt;
    logic          mode_q;
    logic          next_mode;
    logic          vsync_q;
    logic          accept;
    logic          last_pix;
    logic          vsync_rise;
    logic          restart;
    logic          frame_end;
    logic          stall;

    // src_en_o is the registered image of "state is LOAD", so it can gate accepts directly
    assign accept     = src_en_o & src_valid_i;
    assign last_pix   = (x_cnt == X_MAX) && (y_cnt == Y_MAX);
    assign vsync_rise = vsync_i & ~vsync_q;

    assign pix_x_o = x_cnt;
    assign pix_y_o = y_cnt;
    assign sof_o   = accept && (x_cnt == '0) && (y_cnt == '0);
    assign eol_o   = accept && (x_cnt == X_MAX);

    always_comb begin
        next_state = state;
        restart    = 1'b0;
        frame_end  = 1'b0;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    next_state = LOAD;
                    restart    = 1'b1;
                end
            end
            LOAD: begin
                // a late sobel_done_i here belongs to no frame and is ignored
                if (accept) begin
                    if (last_pix) begin
                        next_state = mode_q ? FLUSH : SHOW;
                    end
                end else begin
                    stall = 1'b1;
                    if (t_cnt == T_LAST) begin
                        next_state = ERR;
                    end
                end
            end
            FLUSH: begin
                if (sobel_done_i) begin
                    next_state = SHOW;
                end else begin
                    stall = 1'b1;
                    if (t_cnt == T_LAST) begin
                        next_state = ERR;
                    end
                end
            end
            SHOW: begin
                if (vsync_rise && (v_cnt == V_LAST)) begin
                    frame_end = 1'b1;
                    if (continuous_i) begin
                        next_state = LOAD;
                        restart    = 1'b1;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            ERR: begin
                if (start_i) begin
                    next_state = LOAD;
                    restart    = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
        next_mode = restart ? mode_i : mode_q;
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state   <= IDLE;
            mode_q  <= 1'b0;
            vsync_q <= 1'b0;
        end else begin
            state   <= next_state;
            mode_q  <= next_mode;
            vsync_q <= vsync_i;
        end
    end

    // Raster counters: y advances when x wraps, and wraps itself after the last line
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i || restart) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (accept) begin
            if (x_cnt == X_MAX) begin
                x_cnt <= '0;
                y_cnt <= (y_cnt == Y_MAX) ? '0 : y_cnt + YW'(1);
            end else begin
                x_cnt <= x_cnt + XW'(1);
            end
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            t_cnt <= '0;
            v_cnt <= '0;
        end else begin
            if ((next_state != state) || accept) begin
                t_cnt <= '0;
            end else if (stall) begin
                t_cnt <= t_cnt + TW'(1);
            end
            if (next_state != state) begin
                v_cnt <= '0;
            end else if ((state == SHOW) && vsync_rise) begin
                v_cnt <= v_cnt + VW'(1);
            end
        end
    end

    // Outputs are decoded from the next state so they line up with the state register
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            src_en_o      <= 1'b0;
            sobel_en_o    <= 1'b0;
            disp_sel_o    <= 1'b0;
            busy_o        <= 1'b0;
            frame_done_o  <= 1'b0;
            err_timeout_o <= 1'b0;
            frame_cnt_o   <= 8'd0;
        end else begin
            src_en_o     <= (next_state == LOAD);
            sobel_en_o   <= ((next_state == LOAD) || (next_state == FLUSH)) && next_mode;
            busy_o       <= (next_state != IDLE);
            frame_done_o <= frame_end;
            if (next_state == SHOW) begin
                disp_sel_o <= next_mode;
            end
            if (restart) begin
                err_timeout_o <= 1'b0;
            end else if (next_state == ERR) begin
                err_timeout_o <= 1'b1;
            end
            if (frame_end) begin
                frame_cnt_o <= frame_cnt_o + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Self-checking bench for sobel_frame_ctrl on a 4x2 image with a 16-cycle
// timeout; pixel and frame-completion expectations flow through scoreboards.
module tb_sobel_frame_ctrl;

    logic       sys_clk_i = 1'b0;
    logic       sys_rst_i = 1'b1;
    logic       start_i = 1'b0;
    logic       mode_i = 1'b0;
    logic       continuous_i = 1'b0;
    logic       src_valid_i = 1'b0;
    logic       sobel_done_i = 1'b0;
    logic       vsync_i = 1'b0;
    logic       src_en_o;
    logic [1:0] pix_x_o;
    logic [0:0] pix_y_o;
    logic       sof_o;
    logic       eol_o;
    logic       sobel_en_o;
    logic       disp_sel_o;
    logic       busy_o;
    logic       frame_done_o;
    logic       err_timeout_o;
    logic [7:0] frame_cnt_o;

    typedef struct packed {
        logic [1:0] x;
        logic       y;
        logic       sof;
        logic       eol;
    } pix_t;

    pix_t       pix_q[$];
    logic [7:0] fr_q[$];
    logic [7:0] exp_frames = 8'd0;
    int         checks = 0;
    int         passed = 0;

    sobel_frame_ctrl #(
        .IMG_W(4),
        .IMG_H(2),
        .TIMEOUT(16),
        .SHOW_FRAMES(1)
    ) dut (
        .sys_clk_i(sys_clk_i),
        .sys_rst_i(sys_rst_i),
        .start_i(start_i),
        .mode_i(mode_i),
        .continuous_i(continuous_i),
        .src_valid_i(src_valid_i),
        .src_en_o(src_en_o),
        .pix_x_o(pix_x_o),
        .pix_y_o(pix_y_o),
        .sof_o(sof_o),
        .eol_o(eol_o),
        .sobel_en_o(sobel_en_o),
        .sobel_done_i(sobel_done_i),
        .vsync_i(vsync_i),
        .disp_sel_o(disp_sel_o),
        .busy_o(busy_o),
        .frame_done_o(frame_done_o),
        .err_timeout_o(err_timeout_o),
        .frame_cnt_o(frame_cnt_o)
    );

    always #5 sys_clk_i = ~sys_clk_i;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    // Scoreboard consumer: every accepted pixel and every frame_done pulse pops one expectation
    always @(negedge sys_clk_i) begin
        pix_t pe;
        logic [7:0] fe;
        #2;
        if (src_en_o === 1'b1 && src_valid_i === 1'b1) begin
            checks++;
            if (pix_q.size() == 0) begin
                $display("[TB] FAIL pixel_unexpected: accept at x=%0d y=%0d, no pixel expected", pix_x_o, pix_y_o);
            end else begin
                pe = pix_q.pop_front();
                if ({pix_x_o, pix_y_o, sof_o, eol_o} !== {pe.x, pe.y, pe.sof, pe.eol})
                    $display("[TB] FAIL pixel_scoreboard: got x=%0d y=%0d sof=%0b eol=%0b, expected x=%0d y=%0d sof=%0b eol=%0b",
                             pix_x_o, pix_y_o, sof_o, eol_o, pe.x, pe.y, pe.sof, pe.eol);
                else
                    passed++;
            end
        end
        if (frame_done_o === 1'b1) begin
            checks++;
            if (fr_q.size() == 0) begin
                $display("[TB] FAIL frame_done_unexpected: pulse with frame_cnt_o=%0d, none expected", frame_cnt_o);
            end else begin
                fe = fr_q.pop_front();
                if (frame_cnt_o !== fe)
                    $display("[TB] FAIL frame_cnt_scoreboard: got %0d, expected %0d", frame_cnt_o, fe);
                else
                    passed++;
            end
        end
    end

    task automatic wait_neg();
        @(negedge sys_clk_i);
        #1;
    endtask

    task automatic expect_frame();
        pix_t p;
        for (int yy = 0; yy < 2; yy++) begin
            for (int xx = 0; xx < 4; xx++) begin
                p.x   = 2'(xx);
                p.y   = 1'(yy);
                p.sof = (xx == 0) && (yy == 0);
                p.eol = (xx == 3);
                pix_q.push_back(p);
            end
        end
    endtask

    task automatic expect_frame_done();
        exp_frames = exp_frames + 8'd1;
        fr_q.push_back(exp_frames);
    endtask

    task automatic count_load(output int n);
        n = 0;
        while (src_en_o === 1'b1 && n < 100) begin
            n++;
            wait_neg();
        end
    endtask

    task automatic do_reset();
        wait_neg();
        sys_rst_i = 1'b1;
        start_i = 1'b0;
        src_valid_i = 1'b0;
        vsync_i = 1'b0;
        sobel_done_i = 1'b0;
        continuous_i = 1'b0;
        wait_neg();
        wait_neg();
        sys_rst_i = 1'b0;
        pix_q.delete();
        fr_q.delete();
        exp_frames = 8'd0;
    endtask

    task automatic test_reset();
        sys_rst_i = 1'b1;
        start_i = 1'b1;
        mode_i = 1'b1;
        wait_neg();
        wait_neg();
        checks++;
        if ({src_en_o, sobel_en_o, disp_sel_o, busy_o, frame_done_o, err_timeout_o} !== 6'b0)
            $display("[TB] FAIL reset_flags: got %b, expected 000000",
                     {src_en_o, sobel_en_o, disp_sel_o, busy_o, frame_done_o, err_timeout_o});
        else passed++;
        checks++;
        if (frame_cnt_o !== 8'd0 || pix_x_o !== 2'd0 || pix_y_o !== 1'd0)
            $display("[TB] FAIL reset_counters: got cnt=%0d x=%0d y=%0d, expected 0 0 0", frame_cnt_o, pix_x_o, pix_y_o);
        else passed++;
        sys_rst_i = 1'b0;
        start_i = 1'b0;
        mode_i = 1'b0;
        wait_neg();
        checks++;
        if (busy_o !== 1'b0 || src_en_o !== 1'b0)
            $display("[TB] FAIL reset_idle: got busy=%b src_en=%b, expected 0 0", busy_o, src_en_o);
        else passed++;
    endtask

    task automatic test_raw_frame();
        int n;
        mode_i = 1'b0;
        src_valid_i = 1'b1;
        start_i = 1'b1;
        expect_frame();
        wait_neg();
        start_i = 1'b0;
        checks++;
        if (src_en_o !== 1'b1 || busy_o !== 1'b1 || sobel_en_o !== 1'b0)
            $display("[TB] FAIL raw_start: got src_en=%b busy=%b sobel_en=%b, expected 1 1 0", src_en_o, busy_o, sobel_en_o);
        else passed++;
        count_load(n);
        checks++;
        if (n !== 8) $display("[TB] FAIL raw_load_len: got %0d cycles, expected 8", n);
        else passed++;
        wait_neg();
        checks++;
        if (disp_sel_o !== 1'b0 || busy_o !== 1'b1 || src_en_o !== 1'b0)
            $display("[TB] FAIL raw_show: got disp_sel=%b busy=%b src_en=%b, expected 0 1 0", disp_sel_o, busy_o, src_en_o);
        else passed++;
        expect_frame_done();
        vsync_i = 1'b1;
        wait_neg();
        vsync_i = 1'b0;
        checks++;
        if (frame_done_o !== 1'b1 || frame_cnt_o !== 8'd1 || busy_o !== 1'b0)
            $display("[TB] FAIL raw_done: got done=%b cnt=%0d busy=%b, expected 1 1 0", frame_done_o, frame_cnt_o, busy_o);
        else passed++;
        wait_neg();
        checks++;
        if (frame_done_o !== 1'b0) $display("[TB] FAIL raw_done_pulse: got %b, expected 0", frame_done_o);
        else passed++;
        src_valid_i = 1'b0;
    endtask

    task automatic test_sobel_frame();
        int sob;
        int fl;
        do_reset();
        mode_i = 1'b1;
        src_valid_i = 1'b1;
        start_i = 1'b1;
        expect_frame();
        wait_neg();
        start_i = 1'b0;
        mode_i = 1'b0;
        sob = 0;
        for (int i = 0; i < 8; i++) begin
            if (src_en_o === 1'b1 && sobel_en_o === 1'b1) sob++;
            sobel_done_i = (i == 2);
            wait_neg();
        end
        sobel_done_i = 1'b0;
        checks++;
        if (sob !== 8) $display("[TB] FAIL sobel_load: got %0d LOAD cycles with sobel_en, expected 8", sob);
        else passed++;
        fl = 0;
        for (int i = 0; i < 4; i++) begin
            if (src_en_o === 1'b0 && sobel_en_o === 1'b1 && busy_o === 1'b1) fl++;
            wait_neg();
        end
        if (src_en_o === 1'b0 && sobel_en_o === 1'b1) fl++;
        sobel_done_i = 1'b1;
        wait_neg();
        sobel_done_i = 1'b0;
        checks++;
        if (fl !== 5) $display("[TB] FAIL sobel_flush: got %0d FLUSH cycles, expected 5", fl);
        else passed++;
        checks++;
        if (disp_sel_o !== 1'b1 || sobel_en_o !== 1'b0 || src_en_o !== 1'b0)
            $display("[TB] FAIL sobel_show: got disp_sel=%b sobel_en=%b src_en=%b, expected 1 0 0", disp_sel_o, sobel_en_o, src_en_o);
        else passed++;
        expect_frame_done();
        vsync_i = 1'b1;
        wait_neg();
        vsync_i = 1'b0;
        wait_neg();
        checks++;
        if (frame_cnt_o !== 8'd1 || busy_o !== 1'b0 || disp_sel_o !== 1'b1)
            $display("[TB] FAIL sobel_done: got cnt=%0d busy=%b disp_sel=%b, expected 1 0 1", frame_cnt_o, busy_o, disp_sel_o);
        else passed++;
        src_valid_i = 1'b0;
    endtask

    task automatic test_timeout();
        int n;
        int k;
        mode_i = 1'b0;
        src_valid_i = 1'b1;
        start_i = 1'b1;
        expect_frame();
        wait_neg();
        start_i = 1'b0;
        wait_neg();
        wait_neg();
        src_valid_i = 1'b0;
        repeat (14) wait_neg();
        wait_neg();
        src_valid_i = 1'b1;
        checks++;
        if (err_timeout_o !== 1'b0 || src_en_o !== 1'b1)
            $display("[TB] FAIL gap_15_no_error: got err=%b src_en=%b, expected 0 1", err_timeout_o, src_en_o);
        else passed++;
        count_load(n);
        checks++;
        if (n !== 6) $display("[TB] FAIL gap_remaining: got %0d cycles, expected 6", n);
        else passed++;
        expect_frame_done();
        vsync_i = 1'b1;
        wait_neg();
        vsync_i = 1'b0;

        mode_i = 1'b1;
        start_i = 1'b1;
        expect_frame();
        wait_neg();
        start_i = 1'b0;
        count_load(n);
        checks++;
        if (n !== 8) $display("[TB] FAIL timeout_load: got %0d cycles, expected 8", n);
        else passed++;
        k = 0;
        while (err_timeout_o !== 1'b1 && k < 40) begin
            wait_neg();
            k++;
        end
        checks++;
        if (k !== 16) $display("[TB] FAIL flush_timeout: err after %0d cycles, expected 16", k);
        else passed++;
        checks++;
        if (busy_o !== 1'b1 || sobel_en_o !== 1'b0 || frame_cnt_o !== exp_frames)
            $display("[TB] FAIL err_state: got busy=%b sobel_en=%b cnt=%0d, expected 1 0 %0d", busy_o, sobel_en_o, frame_cnt_o, exp_frames);
        else passed++;
        repeat (3) wait_neg();
        checks++;
        if (err_timeout_o !== 1'b1 || src_en_o !== 1'b0)
            $display("[TB] FAIL err_sticky: got err=%b src_en=%b, expected 1 0", err_timeout_o, src_en_o);
        else passed++;
        mode_i = 1'b0;
        start_i = 1'b1;
        expect_frame();
        wait_neg();
        start_i = 1'b0;
        checks++;
        if (err_timeout_o !== 1'b0 || src_en_o !== 1'b1)
            $display("[TB] FAIL err_restart: got err=%b src_en=%b, expected 0 1", err_timeout_o, src_en_o);
        else passed++;
        count_load(n);
        expect_frame_done();
        vsync_i = 1'b1;
        wait_neg();
        vsync_i = 1'b0;
        checks++;
        if (frame_cnt_o !== exp_frames)
            $display("[TB] FAIL err_frame_cnt: got %0d, expected %0d", frame_cnt_o, exp_frames);
        else passed++;
        src_valid_i = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        int n;
        int k;
        wait_neg();
        mode_i = 1'b0;
        src_valid_i = 1'b1;
        start_i = 1'b1;
        expect_frame();
        wait_neg();
        start_i = 1'b0;
        k = 0;
        while (!(pix_x_o === 2'd2 && pix_y_o === 1'd1) && k < 20) begin
            wait_neg();
            k++;
        end
        checks++;
        if (pix_x_o !== 2'd2 || pix_y_o !== 1'd1)
            $display("[TB] FAIL midrst_reach: got x=%0d y=%0d, expected 2 1", pix_x_o, pix_y_o);
        else passed++;
        sys_rst_i = 1'b1;
        wait_neg();
        sys_rst_i = 1'b0;
        pix_q.delete();
        exp_frames = 8'd0;
        checks++;
        if (src_en_o !== 1'b0 || busy_o !== 1'b0 || pix_x_o !== 2'd0 || pix_y_o !== 1'd0 || frame_cnt_o !== 8'd0)
            $display("[TB] FAIL midrst_idle: got src_en=%b busy=%b x=%0d y=%0d cnt=%0d, expected 0 0 0 0 0",
                     src_en_o, busy_o, pix_x_o, pix_y_o, frame_cnt_o);
        else passed++;
        wait_neg();
        start_i = 1'b1;
        expect_frame();
        wait_neg();
        start_i = 1'b0;
        count_load(n);
        checks++;
        if (n !== 8) $display("[TB] FAIL midrst_restart: got %0d cycles, expected 8", n);
        else passed++;
        expect_frame_done();
        vsync_i = 1'b1;
        wait_neg();
        vsync_i = 1'b0;
        src_valid_i = 1'b0;
    endtask

    task automatic test_continuous();
        int n;
        do_reset();
        mode_i = 1'b0;
        continuous_i = 1'b1;
        src_valid_i = 1'b1;
        start_i = 1'b1;
        expect_frame();
        wait_neg();
        start_i = 1'b0;
        for (int f = 0; f < 3; f++) begin
            count_load(n);
            checks++;
            if (n !== ((f == 0) ? 8 : 6))
                $display("[TB] FAIL cont_load_%0d: got %0d cycles, expected %0d", f, n, (f == 0) ? 8 : 6);
            else passed++;
            if (f == 2) continuous_i = 1'b0;
            else expect_frame();
            expect_frame_done();
            vsync_i = 1'b1;
            wait_neg();
            vsync_i = 1'b0;
            wait_neg();
            vsync_i = 1'b1;
            wait_neg();
            vsync_i = 1'b0;
        end
        wait_neg();
        checks++;
        if (frame_cnt_o !== 8'd3 || busy_o !== 1'b0)
            $display("[TB] FAIL cont_end: got cnt=%0d busy=%b, expected 3 0", frame_cnt_o, busy_o);
        else passed++;
        src_valid_i = 1'b0;
    endtask

    task automatic test_frame_cnt_wrap();
        int n;
        int bad;
        do_reset();
        mode_i = 1'b0;
        continuous_i = 1'b1;
        src_valid_i = 1'b1;
        start_i = 1'b1;
        expect_frame();
        wait_neg();
        start_i = 1'b0;
        bad = 0;
        for (int f = 0; f < 256; f++) begin
            count_load(n);
            if (n != 8) bad++;
            if (f == 255) continuous_i = 1'b0;
            else expect_frame();
            expect_frame_done();
            vsync_i = 1'b1;
            wait_neg();
            vsync_i = 1'b0;
            if (f == 254) begin
                checks++;
                if (frame_cnt_o !== 8'd255) $display("[TB] FAIL wrap_255: got %0d, expected 255", frame_cnt_o);
                else passed++;
            end
        end
        checks++;
        if (bad !== 0) $display("[TB] FAIL wrap_load_len: got %0d bad frames, expected 0", bad);
        else passed++;
        checks++;
        if (frame_cnt_o !== 8'd0 || busy_o !== 1'b0)
            $display("[TB] FAIL wrap_zero: got cnt=%0d busy=%b, expected 0 0", frame_cnt_o, busy_o);
        else passed++;
        src_valid_i = 1'b0;
    endtask

    task automatic test_end();
        wait_neg();
        wait_neg();
        checks++;
        if (pix_q.size() !== 0 || fr_q.size() !== 0)
            $display("[TB] FAIL scoreboard_drain: got %0d pixels and %0d frames pending, expected 0 0", pix_q.size(), fr_q.size());
        else passed++;
    endtask

    initial begin
        $display("[TB] sobel_frame_ctrl bench starting");
        test_reset();
        test_raw_frame();
        test_sobel_frame();
        test_timeout();
        test_reset_mid_frame();
        test_continuous();
        test_frame_cnt_wrap();
        test_end();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
